regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order WB stage and the
//  multi-cycle M-extension (DIV/REM) unit. Buffers one divider result, arbitrates
//  writes and stalls WB when the divider starves. Keeps a per-register pending-write
//  scoreboard for the hazard unit. Sits between WB/divider and the register file.
// PARAMETERS
//  DATA_W    32  write data width
//  ADDR_W    5   register address width (2**ADDR_W registers)
//  MAX_OUT   4   max outstanding divider ops, 1..15
//  MAX_WAIT  3   cycles buffered result may lose arbitration before WB stall, >=1
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous reset, active-high
//  issue_valid in  1       divider op issued this cycle
//  issue_rd   in   ADDR_W  destination of issued op
//  issue_ready out 1       outstanding count < MAX_OUT
//  div_valid  in   1       divider result valid
//  div_rd     in   ADDR_W  result destination
//  div_data   in   DATA_W  result data
//  div_ready  out  1       result buffer empty
//  wb_valid   in   1       WB stage writes this cycle
//  wb_rd      in   ADDR_W  WB destination
//  wb_data    in   DATA_W  WB data
//  stall_wb   out  1       freeze WB stage (registered)
//  rf_we      out  1       to register file we
//  rf_rd      out  ADDR_W  to register file rd_addr
//  rf_data    out  DATA_W  to register file rd_data
//  rs1_addr   in   ADDR_W  decode-stage source 1
//  rs2_addr   in   ADDR_W  decode-stage source 2
//  rs1_busy   out  1       rs1 has pending divider write
//  rs2_busy   out  1       rs2 has pending divider write
// BEHAVIOUR
//  - Reset: scoreboard=0, out_cnt=0, buf empty, wait_cnt=0, stall_wb=0; hence
//    div_ready=1, issue_ready=1, rs*_busy=0; rf_we forced 0 while rst high.
//  - Reset mid-operation discards buffered result and all pending bits.
//  - Buffer: div_valid&&div_ready captures {div_rd,div_data} at edge; 1-cycle latency.
//  - Grant (comb): stall_wb=1 -> buffer; else wb_valid -> WB; else buf valid -> buffer.
//    rf_* driven from winner; rf_we=0 when no winner. While stall_wb=1, wb_* ignored.
//  - Buffer written (or rd==0, consumed with rf_we=0): buf empties, clears
//    scoreboard[rd], out_cnt-1. div_ready stays low that cycle (no same-cycle refill).
//  - wait_cnt: +1 each cycle buf valid and not granted; 0 on grant. On reaching
//    MAX_WAIT, stall_wb=1 next cycle for exactly one cycle; grant drains buffer.
//  - Issue: issue_valid&&issue_ready sets scoreboard[issue_rd] (not for rd==0),
//    out_cnt+1. Issue while !issue_ready: ignored. Same-cycle issue+retire: out_cnt
//    unchanged; same register: set wins.
//  - rsN_busy = scoreboard[rsN_addr] && rsN_addr!=0 (comb).
//  - WB writing a busy register (WAW) is prevented upstream; no check here.
// CONFIGURATION
//  WB_FORWARD_EN defined: rsN_busy also 0 when the buffer is being written to
//   rsN_addr this cycle (hazard unit uses rf_data bypass). Undefined: busy holds
//   until the cycle after the write.
// TESTING
//  - Reset, idle: div_ready=1, issue_ready=1, rf_we=0, rs1_busy=0 for all addresses.
//  - Issue rd=5, result 0x1234 with wb_valid=0 -> next cycle rf_we=1,rf_rd=5,
//    rf_data=0x1234; rs1_addr=5 busy until then (one cycle earlier with _EN).
//  - Buffered result, wb_valid held 1 for 3 cycles -> stall_wb=1 on cycle 4,
//    buffer written, wb_* not written that cycle.
//  - 4 issues without results -> issue_ready=0; 5th issue ignored; retire -> 1.
//  - Result with rd=0 -> rf_we=0, out_cnt decrements, div_ready=1 next cycle.
//  - Assert rst with buffer full and 2 pending -> all busy clear, div_ready=1.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the single register-file write port between the in-order WB stage and
// the multi-cycle DIV/REM unit. One divider result is buffered; WB normally wins
// the write port, but a buffered result that has lost arbitration MAX_WAIT cycles
// in a row stalls WB for one cycle and drains. A per-register pending-write
// scoreboard tells the hazard unit which sources are still waiting on the divider.
//
// Optional feature (macro WB_FORWARD_EN): when defined, a source register is
// reported not busy in the very cycle its buffered result is being written (the
// hazard unit bypasses rf_data). When undefined, busy holds until the next cycle.
//
// Ports
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   issue_valid/issue_rd      divider op issued, destination register
//   issue_ready               outstanding divider ops < MAX_OUT
//   div_valid/div_rd/div_data divider result handshake input
//   div_ready                 result buffer empty
//   wb_valid/wb_rd/wb_data    WB stage write request
//   stall_wb                  freeze WB stage (registered)
//   rf_we/rf_rd/rf_data       register-file write port
//   rs1_addr/rs2_addr         decode-stage source registers
//   rs1_busy/rs2_busy         source has a pending divider write
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int MAX_OUT  = 4,
   parameter int MAX_WAIT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_rd,
   output logic              issue_ready,
   input  logic              div_valid,
   input  logic [ADDR_W-1:0] div_rd,
   input  logic [DATA_W-1:0] div_data,
   output logic              div_ready,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   output logic              stall_wb,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_rd,
   output logic [DATA_W-1:0] rf_data,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic              rs1_busy,
   output logic              rs2_busy
);

   localparam int NREG   = 1 << ADDR_W;
   localparam int CNT_W  = $clog2(MAX_OUT + 1);
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0]  MAX_OUT_C  = CNT_W'(MAX_OUT);
   localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

   logic [NREG-1:0]   sb_q, sb_d;
   logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
   logic              buf_valid_q, buf_valid_d;
   logic [ADDR_W-1:0] buf_rd_q;
   logic [DATA_W-1:0] buf_data_q;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              stall_q, stall_d;

   logic buf_load, issue_acc, wb_grant, buf_grant, buf_lose;

   assign div_ready   = ~buf_valid_q;
   assign issue_ready = (out_cnt_q < MAX_OUT_C);
   assign stall_wb    = stall_q;

   assign buf_load  = div_valid & ~buf_valid_q;
   assign issue_acc = issue_valid & issue_ready;
   // WB requests are ignored during a stall, so the buffer owns the port then.
   assign wb_grant  = ~stall_q & wb_valid;
   assign buf_grant = buf_valid_q & ~wb_grant;
   assign buf_lose  = buf_valid_q & ~buf_grant;

   // NOTE: every output of a combinational block gets a default first so no
   // path leaves it unassigned and a latch cannot be inferred.
   always_comb begin
      rf_we   = 1'b0;
      rf_rd   = '0;
      rf_data = '0;
      if (wb_grant) begin
         rf_we   = 1'b1;
         rf_rd   = wb_rd;
         rf_data = wb_data;
      end else if (buf_grant) begin
         // x0 results are consumed without a write.
         rf_we   = (buf_rd_q != '0);
         rf_rd   = buf_rd_q;
         rf_data = buf_data_q;
      end
      if (rst) rf_we = 1'b0;
   end

   always_comb begin
      sb_d = sb_q;
      // Clear before set so a same-cycle issue to the retiring register wins.
      if (buf_grant) sb_d[buf_rd_q] = 1'b0;
      if (issue_acc && (issue_rd != '0)) sb_d[issue_rd] = 1'b1;

      out_cnt_d = out_cnt_q;
      case ({issue_acc, buf_grant})
         2'b10:   out_cnt_d = out_cnt_q + 1'b1;
         2'b01:   out_cnt_d = out_cnt_q - 1'b1;
         default: out_cnt_d = out_cnt_q;
      endcase

      // Load only when empty, drain only when full: the two never coincide,
      // which also keeps div_ready low in the draining cycle.
      buf_valid_d = buf_valid_q;
      if (buf_load)       buf_valid_d = 1'b1;
      else if (buf_grant) buf_valid_d = 1'b0;

      wait_cnt_d = buf_lose ? wait_cnt_q + 1'b1 : '0;
      // The stall forces a grant, so it lasts exactly one cycle.
      stall_d    = buf_lose && (wait_cnt_d == MAX_WAIT_C);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sb_q        <= '0;
         out_cnt_q   <= '0;
         buf_valid_q <= 1'b0;
         wait_cnt_q  <= '0;
         stall_q     <= 1'b0;
      end else begin
         sb_q        <= sb_d;
         out_cnt_q   <= out_cnt_d;
         buf_valid_q <= buf_valid_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_q     <= stall_d;
      end
   end

   // NOTE: the buffer payload has no reset; it is only observed while
   // buf_valid_q is set, so resetting it would add logic for no behaviour.
   always_ff @(posedge clk) begin
      if (buf_load) begin
         buf_rd_q   <= div_rd;
         buf_data_q <= div_data;
      end
   end

`ifdef WB_FORWARD_EN
   assign rs1_busy = sb_q[rs1_addr] && (rs1_addr != '0) && !(buf_grant && (buf_rd_q == rs1_addr));
   assign rs2_busy = sb_q[rs2_addr] && (rs2_addr != '0) && !(buf_grant && (buf_rd_q == rs2_addr));
`else
   assign rs1_busy = sb_q[rs1_addr] && (rs1_addr != '0);
   assign rs2_busy = sb_q[rs2_addr] && (rs2_addr != '0);
`endif

endmodule
